layer_sequencer: RTL
====================

# layer_sequencer

Controller that streams one fully-connected MLP layer through a single multiply-accumulate unit (`multiply_unit`: 16-bit signed op1, 8-bit signed op2 and bias, 16-bit out, accumulator cleared by its `reset` input). It walks neurons and inputs, fetches activations, weights and biases from synchronous-read memories, and drives the MAC operands and clear. For each neuron it writes one result, optionally ReLU-clamped. Instantiated beside `multiply_unit` in the layer top.

## Interface
- `N_IN`, default 8: inputs per neuron (≥1).
- `N_OUT`, default 4: neurons per layer (≥1).
- `RELU`, default 1: 1 clamps negative results to 0.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begin the layer; sampled only in IDLE.
- `busy`  out  1  high from the cycle after start through the done cycle.
- `done`  out  1  one-cycle pulse after the last result write.
- `in_addr`  out  clog2(N_IN)  activation read address.
- `in_rdata`  in  16  signed activation; valid the cycle after the address.
- `w_addr`  out  clog2(N_IN*N_OUT)  weight address = j*N_IN+i.
- `w_rdata`  in  8  signed weight; 1-cycle read latency.
- `b_addr`  out  clog2(N_OUT)  bias address = j.
- `b_rdata`  in  8  signed bias; 1-cycle read latency.
- `mac_op1`  out  16  registered, to MAC op1.
- `mac_op2`  out  8  registered, to MAC op2.
- `mac_bias`  out  8  registered, to MAC bias.
- `mac_clear`  out  1  registered, to MAC reset.
- `mac_out`  in  16  signed MAC output.
- `res_valid`  out  1  result write strobe.
- `res_addr`  out  clog2(N_OUT)  neuron index j.
- `res_data`  out  16  signed result.

## Operation
- States: IDLE, RUN, DRAIN, WRITE, DONE.
- IDLE: `start` → RUN with j=0, i=0. `start` in any other state is ignored.
- RUN: issues in_addr=i, w_addr=j*N_IN+i, b_addr=j, then i++. After i=N_IN-1 → DRAIN.
- DRAIN: 3 cycles. At the end of the third cycle, register the result; → WRITE.
- WRITE: res_valid=1 for one cycle. If j<N_OUT-1: j++, i=0, → RUN. Else → DONE.
- DONE: done=1 for one cycle, → IDLE.
- Operand pipeline: the rdata returned for term i is registered into mac_op1/op2/bias.
  - mac_clear=1 only alongside term 0 of each neuron.
  - When no term is in flight (IDLE, DRAIN tail, WRITE, DONE): mac_op2=0, mac_op1=0.
  - In IDLE, mac_clear is also held at 1.
  - Rationale: the MAC samples every edge, so zero products hold the accumulator.
- Result: res_data = mac_out if RELU=0 or mac_out≥0, else 0. Accumulator overflow wraps inside the MAC; this block does not saturate or flag it.
- Reset values: state=IDLE, all counters 0, every output 0 except mac_clear=1.
- Reset mid-operation: abort immediately. No further res_valid or done pulse; the next start restarts from neuron 0.

## Timing
- Cycle s: start sampled in IDLE.
- RUN occupies s+1 … s+N_IN.
- Term issued at cycle t: it is on the MAC ports during t+2, and reflected in mac_out during t+3.
- Final mac_out for a neuron is valid in the third DRAIN cycle. res_valid follows in the next cycle.
- Per-neuron period: N_IN+4 cycles.
- First res_valid: cycle s+N_IN+4.
- done: cycle s+N_OUT*(N_IN+4)+1; busy falls with the done cycle.
- Back-to-back neurons: the RUN for neuron j+1 begins the cycle after WRITE for j. The term-0 clear discards the previous sum; no extra bubble.

## Structure
- Shared package `mlp_pkg`:
  - widths DATA_W=16, WEIGHT_W=8, BIAS_W=8;
  - the state enum `seq_state_t`;
  - the DRAIN_CYCLES=3 constant.
- No sub-module: FSM, counters and operand registers are one module. The MAC is instantiated by the parent.

## Test plan
- N_IN=2, N_OUT=1, RELU=0. Acts {3,-4}, weights {5,2}, bias 7 → one res_valid at s+6 with res_addr 0, res_data 14; done at s+7.
- Same data, bias -30, RELU=1 → res_data 0. With RELU=0 → -23.
- N_IN=3, N_OUT=2, distinct nonzero weights per neuron → neuron 1 result excludes neuron 0's sum; res_valid at s+7 and s+14; done at s+15.
- Start held high for the whole run → exactly one layer pass, and no restart until IDLE is reached.
- Reset asserted in the second RUN cycle → next cycle all outputs at reset values. No res_valid or done appears; a fresh start gives correct results.
- Idle 20 cycles between two layers with identical data → identical results. mac_op2=0 and mac_clear=1 throughout the idle period.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared widths, sequencer state encoding and pipeline constants for the MLP layer datapath.
package mlp_pkg;

    localparam int DATA_W       = 16;
    localparam int WEIGHT_W     = 8;
    localparam int BIAS_W       = 8;
    localparam int DRAIN_CYCLES = 3;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        WRITE,
        DONE
    } seq_state_t;

endpackage

// File: rtl/layer_sequencer.sv
// Streams one fully-connected layer through an external MAC: walks neurons/inputs,
// fetches operands from synchronous memories, registers them onto the MAC ports.
module layer_sequencer
    import mlp_pkg::*;
#(
    parameter int N_IN  = 8,
    parameter int N_OUT = 4,
    parameter int RELU  = 1,
    localparam int IW   = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int WW   = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
    localparam int JW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [IW-1:0]       in_addr,
    input  logic [DATA_W-1:0]   in_rdata,
    output logic [WW-1:0]       w_addr,
    input  logic [WEIGHT_W-1:0] w_rdata,
    output logic [JW-1:0]       b_addr,
    input  logic [BIAS_W-1:0]   b_rdata,
    output logic [DATA_W-1:0]   mac_op1,
    output logic [WEIGHT_W-1:0] mac_op2,
    output logic [BIAS_W-1:0]   mac_bias,
    output logic                mac_clear,
    input  logic [DATA_W-1:0]   mac_out,
    output logic                res_valid,
    output logic [JW-1:0]       res_addr,
    output logic [DATA_W-1:0]   res_data
);

    localparam int DW = $clog2(DRAIN_CYCLES);

    seq_state_t          state_q, state_d;
    logic [IW-1:0]       i_q, i_d;
    logic [JW-1:0]       j_q, j_d;
    logic [DW-1:0]       drain_q, drain_d;
    logic                issue_q, issue_d;
    logic                first_q, first_d;
    logic [DATA_W-1:0]   op1_q, op1_d;
    logic [WEIGHT_W-1:0] op2_q, op2_d;
    logic [BIAS_W-1:0]   bias_q, bias_d;
    logic                clear_q, clear_d;
    logic [DATA_W-1:0]   res_q, res_d;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        drain_d = drain_q;
        res_d   = res_q;

        // Term issued this cycle has its rdata back next cycle; track it one stage.
        issue_d = (state_q == RUN);
        first_d = (i_q == '0);

        // Zero operands when nothing is in flight so the always-sampling MAC holds.
        op1_d  = issue_q ? in_rdata : '0;
        op2_d  = issue_q ? w_rdata  : '0;
        bias_d = issue_q ? b_rdata  : '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    i_d     = '0;
                    j_d     = '0;
                end
            end
            RUN: begin
                if (i_q == IW'(N_IN - 1)) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    i_d = i_q + IW'(1);
                end
            end
            DRAIN: begin
                if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
                    state_d = WRITE;
                    res_d   = (RELU != 0 && mac_out[DATA_W-1]) ? '0 : mac_out;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            WRITE: begin
                if (j_q == JW'(N_OUT - 1)) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                    j_d     = j_q + JW'(1);
                    i_d     = '0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Clear rides with term 0; otherwise it is held high exactly while idle.
        clear_d = issue_q ? first_q : (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            drain_q <= '0;
            issue_q <= 1'b0;
            first_q <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            bias_q  <= '0;
            clear_q <= 1'b1;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            drain_q <= drain_d;
            issue_q <= issue_d;
            first_q <= first_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            bias_q  <= bias_d;
            clear_q <= clear_d;
            res_q   <= res_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign res_valid = (state_q == WRITE);
    assign res_addr  = j_q;
    assign res_data  = res_q;
    assign in_addr   = i_q;
    assign b_addr    = j_q;
    assign w_addr    = WW'(int'(j_q) * N_IN + int'(i_q));
    assign mac_op1   = op1_q;
    assign mac_op2   = op2_q;
    assign mac_bias  = bias_q;
    assign mac_clear = clear_q;

endmodule
